// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction prefetch path.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } prefetch_state_t;

    localparam logic [15:0] RESET_CS = 16'hFFFF;
    localparam logic [15:0] RESET_IP = 16'h0000;

    // Physical byte address wraps at 1 MiB; the bus takes word addresses.
    function automatic logic [18:0] word_address(input logic [15:0] cs, input logic [15:0] ip);
        logic [19:0] phys;
        phys = {cs, 4'h0} + {4'h0, ip};
        return phys[19:1];
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular byte queue: 1- or 2-byte push, registered 1-byte pop, synchronous clear.
module prefetch_fifo #(
    parameter int DEPTH = 6,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [1:0]    push_cnt,
    input  logic [15:0]   push_data,
    input  logic          pop,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] count
);

    logic [7:0]    buf_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_p1;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned n);
        int unsigned s;
        s = {{(32-PW){1'b0}}, p} + n;
        if (s >= DEPTH)
            s = s - DEPTH;
        return s[PW-1:0];
    endfunction

    assign wr_ptr_p1 = ptr_add(wr_ptr, 32'd1);

    // push_data[7:0] is the older byte and lands first.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push_cnt != 2'd0)
                buf_q[wr_ptr] <= push_data[7:0];
            if (push_cnt == 2'd2)
                buf_q[wr_ptr_p1] <= push_data[15:8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            rd_data <= 8'h00;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_data <= buf_q[rd_ptr];
                rd_ptr  <= ptr_add(rd_ptr, 32'd1);
            end
            if (push_cnt != 2'd0)
                wr_ptr <= ptr_add(wr_ptr, 32'(push_cnt));
            count <= count + CW'(push_cnt) - CW'(pop);
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch: fetches code words at CS:IP and queues them as bytes for the decoder.
//   state   | meaning
//   IDLE    | no bus access; issue a fetch once the queue has room for it
//   FETCH   | bus read outstanding; data is pushed on mem_ack
//   DISCARD | flushed mid-access; wait for mem_ack and drop its data
module prefetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [15:0] load_cs,
    input  logic [15:0] load_ip,
    output logic        mem_access,
    input  logic        mem_ack,
    output logic [18:0] mem_address,
    input  logic [15:0] mem_data,
    input  logic        fifo_rd_en,
    output logic [7:0]  fifo_rd_data,
    output logic        fifo_empty
);

    localparam int CW = $clog2(DEPTH + 1);

    prefetch_state_t state;
    prefetch_state_t state_next;

    logic [15:0]   cs;
    logic [15:0]   fetch_ip;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_after;
    logic [CW-1:0] free_bytes;
    logic [CW-1:0] need;
    logic          has_room;
    logic          rd_accept;
    logic          issue;
    logic [1:0]    push_cnt;
    logic [15:0]   push_data;

    assign fifo_empty = (fifo_count == '0);
    assign rd_accept  = fifo_rd_en && !fifo_empty && !flush;
    assign mem_access = (state != IDLE);

    // Room is judged after this cycle's pop so a read can unblock a fetch immediately.
    assign count_after = fifo_count - CW'(rd_accept);
    assign free_bytes  = CW'(DEPTH) - count_after;
    assign need        = fetch_ip[0] ? CW'(1) : CW'(2);
    assign has_room    = (free_bytes >= need);

    // An odd IP only wants the high byte of the fetched word.
    assign push_data = fetch_ip[0] ? {8'h00, mem_data[15:8]} : mem_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push_cnt   = 2'd0;
        case (state)
            IDLE: begin
                if (!flush && has_room) begin
                    state_next = FETCH;
                    issue      = 1'b1;
                end
            end
            FETCH: begin
                if (flush) begin
                    state_next = mem_ack ? IDLE : DISCARD;
                end else if (mem_ack) begin
                    push_cnt   = fetch_ip[0] ? 2'd1 : 2'd2;
                    state_next = IDLE;
                end
            end
            DISCARD: begin
                if (mem_ack)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs       <= RESET_CS;
            fetch_ip <= RESET_IP;
        end else if (flush) begin
            cs       <= load_cs;
            fetch_ip <= load_ip;
        end else if (push_cnt != 2'd0) begin
            fetch_ip <= fetch_ip + {14'd0, push_cnt};
        end
    end

    // Latched at issue so the bus sees a stable address even if a flush reloads CS:IP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mem_address <= word_address(RESET_CS, RESET_IP);
        else if (issue)
            mem_address <= word_address(cs, fetch_ip);
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop       (rd_accept),
        .rd_data   (fifo_rd_data),
        .count     (fifo_count)
    );

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Instruction prefetch unit directly upstream of the ModR/M decoder.
- Fetches 16-bit code words from memory at CS:IP and pushes them as bytes into a small FIFO.
- Presents the FIFO read port (fifo_rd_en / fifo_rd_data / fifo_empty) that the decoder consumes.
- Supports a flush with a new CS:IP when a branch is taken.

Parameters:
- DEPTH, 6, FIFO capacity in bytes (even, >= 2).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- flush  in  1  discard queued bytes and restart fetching at load_cs:load_ip
- load_cs  in  16  new code segment, sampled when flush=1
- load_ip  in  16  new instruction pointer, sampled when flush=1
- mem_access  out  1  memory read request; held high until mem_ack
- mem_ack  in  1  single-cycle completion strobe; mem_data valid in the same cycle
- mem_address  out  19  word address [19:1] = ((cs << 4) + fetch_ip) >> 1, 20-bit sum wraps
- mem_data  in  16  read data, little-endian; low byte = even address
- fifo_rd_en  in  1  pop request from the decoder
- fifo_rd_data  out  8  registered byte popped on the previous accepted read
- fifo_empty  out  1  high when the FIFO holds 0 bytes

Behaviour:
- Reset:
  - count=0, fifo_empty=1, fifo_rd_data=0, mem_access=0.
  - cs=0xFFFF, fetch_ip=0x0000 (reset vector FFFF0h).
  - FSM enters IDLE.
- FSM states: IDLE, FETCH, DISCARD.
- IDLE -> FETCH when free space (DEPTH - count) is at least the number of bytes the next fetch yields:
  - 2 if fetch_ip is even;
  - 1 if fetch_ip is odd.
  - mem_access asserts in the cycle the FSM enters FETCH.
  - mem_address is held stable through the whole access.
- FETCH + mem_ack:
  - Even fetch_ip: push mem_data[7:0], then mem_data[15:8] in the same cycle (2-byte write); fetch_ip += 2.
  - Odd fetch_ip: push mem_data[15:8] only; fetch_ip += 1.
  - fetch_ip wraps mod 2^16; cs is unchanged.
  - Return to IDLE. Back-to-back fetches are allowed: IDLE is re-evaluated on the next cycle.
- Space check uses count after this cycle's pop, so a pop can free room for a same-cycle fetch decision.
- Read port:
  - A read is accepted when fifo_rd_en=1, fifo_empty=0 and flush=0.
  - On an accepted read, fifo_rd_data updates at the next rising edge with the oldest byte, and count decrements.
  - fifo_rd_data holds its value otherwise.
  - A read while empty has no effect and no underflow.
- Simultaneous push and pop in one cycle: count += pushed - 1. Push order is preserved.
- Full: no fetch is issued; count never exceeds DEPTH. A 2-byte push occurs only if 2 slots were free when the fetch was issued.
- Flush:
  - Takes effect at the next edge: count=0, read/write pointers=0, cs=load_cs, fetch_ip=load_ip.
  - fifo_rd_data holds its value. fifo_empty=1 from the next cycle.
  - Flush has priority over a same-cycle read and a same-cycle mem_ack push.
  - Flush in IDLE: normal fetching resumes from the new address on the following cycle.
  - Flush in FETCH without mem_ack: FSM goes to DISCARD and mem_access stays high (bus access cannot be aborted). The mem_ack data is dropped, then IDLE.
  - Flush in DISCARD: re-latches the new cs/ip and stays in DISCARD.
- Reset mid-access drops mem_access immediately (asynchronous); the bus is assumed reset too.
- Latency: first byte is visible (fifo_empty=0) one cycle after the mem_ack edge.

Decomposition:
- Shared package cpu_pkg:
  - prefetch_state_t enum (IDLE, FETCH, DISCARD);
  - RESET_CS=16'hFFFF;
  - RESET_IP=16'h0000.
- Sub-module prefetch_fifo (parameter DEPTH):
  - circular byte buffer with 1- or 2-byte push (push_cnt[1:0]), 1-byte registered pop, clear input, count output.
  - The top level holds the FSM, address generation and flush logic.

Test Plan:
- Reset then mem_ack with mem_data=16'h3412 -> mem_address=19'h7FFF8; next cycle fifo_empty=0; two pops yield 8'h12 then 8'h34; fetch_ip=0x0002.
- flush with load_cs=0x1000, load_ip=0x0005 -> mem_address=19'h08002; mem_data=16'hAB00 pushes only 8'hAB; next fetch at ip=0x0006 is a full word.
- No pops, mem_ack always 1 -> exactly DEPTH=6 bytes in 3 fetches, then mem_access=0. One pop -> still no fetch (1 slot, even ip). A second pop -> fetch issued.
- flush while mem_access=1 before mem_ack -> mem_access held until ack. Acked data 16'hDEAD is not pushed; fifo_empty stays 1; next fetch uses the new address.
- load_ip=0xFFFE, mem_ack -> fetch_ip wraps to 0x0000 with cs unchanged; next mem_address = cs*16 >> 1.
- Simultaneous accepted pop and 2-byte push at count=3 -> count=4, byte order preserved. fifo_rd_en while empty -> fifo_rd_data unchanged, count stays 0.
